// File: rtl/lif_sched_pkg.sv
// Shared types for the LIF adder scheduler: FSM state encoding and per-neuron cycle cost.
// Latency: n/a (types only).
// Backpressure: n/a.
package lif_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NEG   = 3'd2,
        LEAK  = 3'd3,
        INTEG = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int CYCLES_PER_NEURON = 5;

endpackage

// File: rtl/nbit_adder.sv
// Unsigned n-bit adder with carry-out in s[n]; the single arithmetic resource shared by the sweep.
// Latency: combinational.
// Backpressure: none.
module nbit_adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n:0]   s
);

    assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/lif_adder_scheduler.sv
// Sweeps N_NEURONS LIF neurons (leak, integrate, fire) through one shared adder; optional LIF_REFRACTORY_EN.
// Latency: done pulses 5*N_NEURONS+1 cycles after the edge that accepts start.
// Backpressure: start is ignored while a sweep is running; no output stall.
module lif_adder_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int WIDTH        = 8,
    parameter int THRESHOLD    = 200,
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRAC_STEPS = 2,
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_NEURONS*WIDTH-1:0] current_in,
    input  logic [IW-1:0]              mon_idx,
    output logic                       busy,
    output logic                       done,
    output logic [N_NEURONS-1:0]       spikes,
    output logic [WIDTH-1:0]           membrane_mon
);

    localparam logic [WIDTH-1:0] TH_W = WIDTH'(THRESHOLD);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     u_q;
    logic [WIDTH-1:0]     tmp_q;
    logic [N_NEURONS-1:0] spk_acc;
    logic [WIDTH-1:0]     membrane [N_NEURONS];
    logic [WIDTH-1:0]     cur_q    [N_NEURONS];

    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH:0]       add_s;
    logic                 in_refrac;
    logic                 fire;

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    logic [RW-1:0] refrac [N_NEURONS];
    assign in_refrac = (refrac[idx] != '0);
`else
    assign in_refrac = 1'b0;
`endif

    assign fire = (u_q >= TH_W) && !in_refrac;

    // Operands held at zero outside the three arithmetic states so the adder does not toggle.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            NEG: begin
                add_a = ~(u_q >> LEAK_SHIFT);
                add_b = WIDTH'(1);
            end
            LEAK: begin
                add_a = u_q;
                add_b = tmp_q;
            end
            INTEG: begin
                add_a = u_q;
                add_b = in_refrac ? '0 : cur_q[idx];
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    nbit_adder #(.n(WIDTH)) u_adder (
        .a (add_a),
        .b (add_b),
        .s (add_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            u_q     <= '0;
            tmp_q   <= '0;
            spk_acc <= '0;
            spikes  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                membrane[k] <= '0;
                cur_q[k]    <= '0;
`ifdef LIF_REFRACTORY_EN
                refrac[k]   <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_NEURONS; k++)
                            cur_q[k] <= current_in[k*WIDTH +: WIDTH];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    u_q   <= membrane[idx];
                    state <= NEG;
                end
                NEG: begin
                    tmp_q <= add_s[WIDTH-1:0];
                    state <= LEAK;
                end
                LEAK: begin
                    u_q   <= add_s[WIDTH-1:0];
                    state <= INTEG;
                end
                INTEG: begin
                    u_q   <= add_s[WIDTH] ? '1 : add_s[WIDTH-1:0];
                    state <= WRITE;
                end
                WRITE: begin
                    spk_acc[idx]  <= fire;
                    membrane[idx] <= fire ? '0 : u_q;
`ifdef LIF_REFRACTORY_EN
                    if (in_refrac)
                        refrac[idx] <= refrac[idx] - 1'b1;
                    else if (fire)
                        refrac[idx] <= RW'(REFRAC_STEPS);
`endif
                    if (idx == IW'(N_NEURONS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    spikes <= spk_acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign membrane_mon = (int'(mon_idx) < N_NEURONS) ? membrane[mon_idx] : '0;

endmodule

// File: tb/tb_lif_adder_scheduler.sv
// Randomised and directed bench for lif_adder_scheduler against a plain-arithmetic LIF model.
// Honours LIF_REFRACTORY_EN when defined at compile time.
module tb_lif_adder_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] current_in;
    logic [1:0]  mon_idx;
    logic        busy;
    logic        done;
    logic [3:0]  spikes;
    logic [7:0]  membrane_mon;

    int errors = 0;
    int checks = 0;

    int         mm [4];
    int         mr [4];
    logic [3:0] mspk;

`ifdef LIF_REFRACTORY_EN
    localparam int REFRAC_LOAD = 2;
`else
    localparam int REFRAC_LOAD = 0;
`endif
    localparam int LAT = 21;

    lif_adder_scheduler #(
        .N_NEURONS(4), .WIDTH(8), .THRESHOLD(200), .LEAK_SHIFT(3), .REFRAC_STEPS(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .current_in   (current_in),
        .mon_idx      (mon_idx),
        .busy         (busy),
        .done         (done),
        .spikes       (spikes),
        .membrane_mon (membrane_mon)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mm[k] = 0;
            mr[k] = 0;
        end
        mspk = '0;
    endfunction

    function automatic void model_sweep(input logic [31:0] cur);
        for (int k = 0; k < 4; k++) begin
            int u;
            int c;
            c = int'(cur[k*8 +: 8]);
            u = mm[k] - (mm[k] / 8);
            if (mr[k] > 0) begin
                mr[k]   = mr[k] - 1;
                mm[k]   = u;
                mspk[k] = 1'b0;
            end else begin
                u = u + c;
                if (u > 255) u = 255;
                if (u >= 200) begin
                    mspk[k] = 1'b1;
                    mm[k]   = 0;
                    mr[k]   = REFRAC_LOAD;
                end else begin
                    mspk[k] = 1'b0;
                    mm[k]   = u;
                end
            end
        end
    endfunction

    // Drives one sweep; returns cycles from the accepting edge to done (bounded).
    task automatic run_sweep(input logic [31:0] cur, input bit poke, output int cyc);
        @(posedge clk);
        @(negedge clk);
        current_in = cur;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 3) begin
                start      = 1'b1;
                current_in = ~cur;
            end
            if (poke && cyc == 4) start = 1'b0;
        end
        model_sweep(cur);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; current_in = '0; mon_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (spikes !== 4'b0) begin errors++; $display("FAIL reset_spikes: got %b expected 0000", spikes); end
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            mon_idx = 2'(k); #1;
            checks++;
            if (membrane_mon !== 8'd0) begin errors++; $display("FAIL reset_mem%0d: got %0d expected 0", k, membrane_mon); end
        end
    endtask

    task automatic test_zero_sweep();
        int cyc;
        run_sweep(32'h0, 1'b0, cyc);
        checks++;
        if (cyc != LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", cyc, LAT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done: got %b expected 0", busy); end
        checks++;
        if (spikes !== 4'b0) begin errors++; $display("FAIL zero_spikes: got %b expected 0000", spikes); end
        for (int k = 0; k < 4; k++) begin
            mon_idx = 2'(k); #1;
            checks++;
            if (membrane_mon !== 8'd0) begin errors++; $display("FAIL zero_mem%0d: got %0d expected 0", k, membrane_mon); end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_integrate();
        int cyc;
        int exp_mem [3] = '{100, 188, 0};
        logic [3:0] exp_spk [3] = '{4'b0000, 4'b0000, 4'b0001};
        for (int s = 0; s < 3; s++) begin
            run_sweep(32'h0000_0064, 1'b0, cyc);
            mon_idx = 2'd0; #1;
            checks++;
            if (membrane_mon !== 8'(exp_mem[s])) begin
                errors++; $display("FAIL integ_mem0_s%0d: got %0d expected %0d", s + 1, membrane_mon, exp_mem[s]);
            end
            checks++;
            if (spikes !== exp_spk[s]) begin
                errors++; $display("FAIL integ_spikes_s%0d: got %b expected %b", s + 1, spikes, exp_spk[s]);
            end
        end
    endtask

    task automatic test_leak_floor();
        int cyc;
        run_sweep(32'h0000_0007, 1'b0, cyc);
        for (int s = 0; s < 3; s++) begin
            run_sweep(32'h0, 1'b0, cyc);
            mon_idx = 2'd0; #1;
            checks++;
            if (membrane_mon !== 8'd7) begin
                errors++; $display("FAIL leak_floor_s%0d: got %0d expected 7", s + 1, membrane_mon);
            end
        end
    endtask

    task automatic test_refractory();
        int cyc;
`ifdef LIF_REFRACTORY_EN
        logic exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
        logic exp [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int s = 0; s < 4; s++) begin
            run_sweep(32'h0000_FF00, 1'b0, cyc);
            checks++;
            if (spikes[1] !== exp[s]) begin
                errors++; $display("FAIL refrac_spike1_s%0d: got %b expected %b", s + 1, spikes[1], exp[s]);
            end
            checks++;
            if (spikes !== mspk) begin
                errors++; $display("FAIL refrac_model_s%0d: got %b expected %b", s + 1, spikes, mspk);
            end
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        int extra;
        logic [31:0] cur;
        cur = $urandom;
        run_sweep(cur, 1'b1, cyc);
        checks++;
        if (cyc != LAT) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", cyc, LAT); end
        checks++;
        if (spikes !== mspk) begin errors++; $display("FAIL busy_spikes: got %b expected %b", spikes, mspk); end
        for (int k = 0; k < 4; k++) begin
            mon_idx = 2'(k); #1;
            checks++;
            if (membrane_mon !== 8'(mm[k])) begin
                errors++; $display("FAIL busy_mem%0d: got %0d expected %0d", k, membrane_mon, mm[k]);
            end
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_random();
        int cyc;
        logic [31:0] cur;
        for (int s = 0; s < 8; s++) begin
            cur = $urandom;
            run_sweep(cur, 1'b0, cyc);
            checks++;
            if (cyc != LAT) begin errors++; $display("FAIL rand_latency_s%0d: got %0d expected %0d", s, cyc, LAT); end
            checks++;
            if (spikes !== mspk) begin errors++; $display("FAIL rand_spikes_s%0d: got %b expected %b", s, spikes, mspk); end
            for (int k = 0; k < 4; k++) begin
                mon_idx = 2'(k); #1;
                checks++;
                if (membrane_mon !== 8'(mm[k])) begin
                    errors++; $display("FAIL rand_mem_s%0d_n%0d: got %0d expected %0d", s, k, membrane_mon, mm[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        run_sweep(32'hFFFF_FFFF, 1'b0, cyc);
        checks++;
        if (spikes !== mspk) begin errors++; $display("FAIL mid_pre_spikes: got %b expected %b", spikes, mspk); end
        @(posedge clk);
        @(negedge clk);
        current_in = 32'h3050_7090;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl: got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (spikes !== 4'b0) begin errors++; $display("FAIL mid_spikes: got %b expected 0000", spikes); end
        for (int k = 0; k < 4; k++) begin
            mon_idx = 2'(k); #1;
            checks++;
            if (membrane_mon !== 8'd0) begin errors++; $display("FAIL mid_mem%0d: got %0d expected 0", k, membrane_mon); end
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_zero_sweep();
        test_integrate();
        test_reset();
        test_leak_floor();
        test_reset();
        test_refractory();
        test_busy_start();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
